sid_voice_vca: RTL
==================

// Module: sid_voice_vca
// PURPOSE
//  Voltage-controlled amplifier stage for one SID voice; sits directly downstream of the envelope generator.
//  On each sample strobe it captures the 12-bit oscillator waveform and the 8-bit envelope volume.
//  It forms signed(wave) x vol with a serial shift-add multiplier on the fast clock.
//  It presents a registered signed product with a one-cycle valid pulse to the voice mixer.
// PARAMETERS
//  WAVE_W     12     oscillator waveform width, unsigned offset-binary
//  ENV_W      8      envelope volume width, unsigned
//  DC_OFFSET  13'sd0 signed bias added to centred waveform; used only with SID_VCA_DC_OFFSET_EN
// PORTS
//  clk        in   1                 system clock
//  reset      in   1                 asynchronous, active-high reset
//  clk_en     in   1                 sample strobe: capture operands, start multiply
//  wave       in   WAVE_W            oscillator output, unsigned
//  vol        in   ENV_W             envelope volume, unsigned
//  out        out  WAVE_W+ENV_W      signed product, registered
//  out_valid  out  1                 one-cycle pulse when out updates
//  busy       out  1                 multiply in progress
//  overrun    out  1                 sticky: strobe arrived while busy
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, out=0, out_valid=0, busy=0, overrun=0, accumulator=0, bit count=0.
//  Operand A: a = wave - 2**(WAVE_W-1), signed WAVE_W bits, range -2048..2047.
//  Operand B: b = vol, unsigned 0..255, zero-extended.
//  State IDLE: clk_en=1 at edge E0 -> latch a and b, acc=0, cnt=0 -> MUL; busy=1 from E0.
//  State MUL: one bit per clk, independent of clk_en. If b[cnt]=1: acc += a <<< cnt (sign-extended to WAVE_W+ENV_W).
//   Then cnt++. After cnt=ENV_W-1 (edge E8) -> DONE.
//  State DONE: at edge E9, out<=acc, out_valid=1 for exactly one cycle, busy=0 -> IDLE.
//  Latency: fixed 9 clks from strobe edge to out_valid edge, for all operands including vol=0.
//  Maximum strobe rate: one strobe per 10 clks.
//  Product range: -522240..+521985; fits WAVE_W+ENV_W signed bits with no overflow and no saturation.
//  out holds its value between updates. out_valid is never asserted twice for one strobe.
//  Strobe while busy (MUL or DONE): abort current op, latch new operands, restart at cnt=0, set overrun.
//   The aborted result is never output. overrun clears only on reset.
//  Strobe in the same cycle out_valid is high (IDLE): accepted normally with no overrun.
//  Reset mid-multiply: abort immediately; no out_valid after reset deasserts until a new strobe.
// CONFIGURATION
//  SID_VCA_DC_OFFSET_EN defined:
//   a = clamp(wave - 2**(WAVE_W-1) + DC_OFFSET, -2048, 2047), computed at capture.
//   Models 6581 waveform DC bias leaking through the VCA.
//  Not defined: DC_OFFSET is ignored; a is the pure centred waveform; no clamp logic is synthesised.
// STRUCTURE
//  sid_pkg: SID_WAVE_W=12, SID_ENV_W=8, SID_VCA_OUT_W=20, typedef vca_state_t {IDLE, MUL, DONE}.
//  One sub-module: sid_serial_mul (signed x unsigned shift-add core with start/done).
//  The VCA wrapper owns strobe capture, centring, the optional DC clamp, overrun and the output register.
// TESTING
//  1. wave=12'hFFF, vol=8'hFF, strobe -> out_valid 9 clks later, out=20'h7F701 (+521985).
//  2. wave=12'h000, vol=8'hFF -> out=20'h80800 (-522240).
//  3. wave=12'h800, vol=8'h5D -> out=0.
//     wave=12'hABC, vol=0 -> out=0, still 9-clk latency.
//  4. Strobe A (wave=12'hFFF, vol=1).
//     At +4 clks, strobe B (wave=12'h801, vol=2) -> single out_valid 9 clks after B, out=2, overrun=1.
//  5. reset pulse at +5 clks into a multiply -> out=0, busy=0, overrun=0, no out_valid afterwards.
//     Next strobe works normally.
//  6. SID_VCA_DC_OFFSET_EN, DC_OFFSET=100, wave=12'hFFF, vol=8'h10 -> out=2047*16=32752 (clamped).
//     Without the macro: out=32752 also; with wave=12'h800 -> 1600 vs 0.

Source files
------------

// File: rtl/sid_pkg.sv
// sid_pkg: shared widths and state type for the SID voice VCA slice.
//   SID_WAVE_W    - oscillator waveform width (unsigned offset-binary)
//   SID_ENV_W     - envelope volume width (unsigned)
//   SID_VCA_OUT_W - signed product width presented to the voice mixer
//   vca_state_t   - VCA control states, also exported on the debug port
package sid_pkg;

    localparam int SID_WAVE_W    = 12;
    localparam int SID_ENV_W     = 8;
    localparam int SID_VCA_OUT_W = SID_WAVE_W + SID_ENV_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } vca_state_t;

endpackage

// File: rtl/sid_serial_mul.sv
// sid_serial_mul: signed x unsigned shift-add multiplier, one multiplier bit
// per clock.
//   clk, reset : clock, asynchronous active-high reset
//   start      : load operands, clear accumulator, begin at bit 0 (wins over
//                an operation already in flight)
//   a          : signed multiplicand, A_W bits
//   b          : unsigned multiplier, B_W bits
//   acc        : running / final product, P_W bits signed
//   done       : high during the cycle whose edge adds the last multiplier bit
module sid_serial_mul #(
    parameter int A_W = 12,
    parameter int B_W = 8,
    parameter int P_W = A_W + B_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [A_W-1:0] a,
    input  logic        [B_W-1:0] b,
    output logic signed [P_W-1:0] acc,
    output logic                  done
);

    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(B_W - 1);

    logic signed [P_W-1:0] a_ext;
    logic        [B_W-1:0] b_r;
    logic        [CNT_W-1:0] cnt;
    logic                  run;

    // Every bit position costs one clock whether or not it adds, so the
    // latency is independent of the operand values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_ext <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (start) begin
            a_ext <= {{(P_W-A_W){a[A_W-1]}}, a};
            b_r   <= b;
            acc   <= '0;
            cnt   <= '0;
            run   <= 1'b1;
        end else if (run) begin
            if (b_r[cnt]) begin
                acc <= acc + (a_ext <<< cnt);
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                run <= 1'b0;
            end
        end
    end

    assign done = run && (cnt == LAST);

endmodule

// File: rtl/sid_voice_vca.sv
// sid_voice_vca: voltage-controlled amplifier for one SID voice.
// Captures wave/vol on each clk_en strobe, multiplies the centred waveform by
// the volume serially, and presents a registered signed product.
//   clk, reset : clock, asynchronous active-high reset
//   clk_en     : sample strobe; capture operands and start a multiply
//   wave       : oscillator output, unsigned offset-binary
//   vol        : envelope volume, unsigned
//   out        : signed product, held between updates
//   out_valid  : one-cycle pulse when out updates
//   busy       : multiply in progress
//   overrun    : sticky, a strobe arrived while busy (cleared by reset only)
//   state      : current control state (debug)
// Optional build macro SID_VCA_DC_OFFSET_EN: adds DC_OFFSET to the centred
// waveform at capture and clamps to the signed WAVE_W range. Without it the
// DC_OFFSET parameter does not exist and no clamp logic is built.
module sid_voice_vca
    import sid_pkg::*;
#(
    parameter int WAVE_W = SID_WAVE_W,
    parameter int ENV_W  = SID_ENV_W
`ifdef SID_VCA_DC_OFFSET_EN
    ,
    parameter logic signed [12:0] DC_OFFSET = 13'sd0
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clk_en,
    input  logic        [WAVE_W-1:0]         wave,
    input  logic        [ENV_W-1:0]          vol,
    output logic signed [WAVE_W+ENV_W-1:0]   out,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun,
    output vca_state_t                       state
);

    localparam int P_W = WAVE_W + ENV_W;

    logic signed [WAVE_W-1:0] a_cent;
    logic signed [P_W-1:0]    mul_acc;
    logic                     mul_done;
    logic                     mul_start;
    logic                     out_load;
    logic                     ovr_set;
    vca_state_t               state_next;

`ifdef SID_VCA_DC_OFFSET_EN
    localparam logic signed [WAVE_W+1:0] HALF  = (WAVE_W+2)'(2**(WAVE_W-1));
    localparam logic signed [WAVE_W+1:0] A_MAX = (WAVE_W+2)'(2**(WAVE_W-1) - 1);
    localparam logic signed [WAVE_W+1:0] A_MIN = -HALF;
    localparam logic signed [WAVE_W+1:0] DC_EXT = (WAVE_W+2)'(DC_OFFSET);

    logic signed [WAVE_W+1:0] a_sum;

    always_comb begin
        a_sum = $signed({2'b00, wave}) - HALF + DC_EXT;
        if (a_sum > A_MAX) begin
            a_cent = A_MAX[WAVE_W-1:0];
        end else if (a_sum < A_MIN) begin
            a_cent = A_MIN[WAVE_W-1:0];
        end else begin
            a_cent = a_sum[WAVE_W-1:0];
        end
    end
`else
    // Subtracting the mid-scale code from offset-binary is just an MSB flip.
    assign a_cent = {~wave[WAVE_W-1], wave[WAVE_W-2:0]};
`endif

    sid_serial_mul #(
        .A_W (WAVE_W),
        .B_W (ENV_W),
        .P_W (P_W)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .a     (a_cent),
        .b     (vol),
        .acc   (mul_acc),
        .done  (mul_done)
    );

    // A strobe in MUL or DONE restarts the multiplier with the new operands;
    // the abandoned product never reaches out.
    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        out_load   = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            IDLE: begin
                if (clk_en) begin
                    mul_start  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (clk_en) begin
                    mul_start  = 1'b1;
                    ovr_set    = 1'b1;
                    state_next = MUL;
                end else if (mul_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (clk_en) begin
                    mul_start  = 1'b1;
                    ovr_set    = 1'b1;
                    state_next = MUL;
                end else begin
                    out_load   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= out_load;
            busy      <= (state_next != IDLE);
            if (out_load) begin
                out <= mul_acc;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
